// File: rtl/psum_pkg.sv
// Shared types and sizes for the partial-sum drain controller.
// PSUM_SAT_EN (see psum_lane_add) selects saturating accumulate.
package psum_pkg;

    localparam int COL        = 8;
    localparam int PSUM_BW    = 16;
    localparam int ADDR_BW    = 6;
    localparam int RD_LAT_DEF = 2;
    localparam int ROW_BW     = PSUM_BW * COL;

    // Signed clamp bounds for one lane.
    localparam logic [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_POP  = 3'd2,
        S_LAT  = 3'd3,
        S_RD   = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_e;

endpackage

// File: rtl/psum_drain_ctrl_if.sv
// Job handshake, output-FIFO pop port and psum SRAM port of the drain controller.
// master = controller side, slave = layer controller / FIFO / SRAM side.
interface psum_drain_ctrl_if;

    logic                            start;
    logic [psum_pkg::ADDR_BW:0]      num_rows;
    logic [psum_pkg::ADDR_BW-1:0]    base_addr;
    logic                            acc;
    logic                            ofifo_valid;
    logic                            ofifo_rd;
    logic [psum_pkg::ROW_BW-1:0]     ofifo_out;
    logic                            mem_cen;
    logic                            mem_wen;
    logic [psum_pkg::ADDR_BW-1:0]    mem_addr;
    logic [psum_pkg::ROW_BW-1:0]     mem_d;
    logic [psum_pkg::ROW_BW-1:0]     mem_q;
    logic                            busy;
    logic                            done;

    // start is a one-cycle pulse honoured only when busy is low; done is a one-cycle
    // pulse; ofifo_rd pops one row whose data appears rd_lat cycles later.
    modport master (
        input  start, num_rows, base_addr, acc, ofifo_valid, ofifo_out, mem_q,
        output ofifo_rd, mem_cen, mem_wen, mem_addr, mem_d, busy, done
    );

    modport slave (
        output start, num_rows, base_addr, acc, ofifo_valid, ofifo_out, mem_q,
        input  ofifo_rd, mem_cen, mem_wen, mem_addr, mem_d, busy, done
    );

endinterface

// File: rtl/psum_lane_add.sv
// One psum lane adder: modular wrap by default, signed saturation when
// PSUM_SAT_EN is defined.
module psum_lane_add
    import psum_pkg::*;
(
    input  logic [PSUM_BW-1:0] a_i,
    input  logic [PSUM_BW-1:0] b_i,
    output logic [PSUM_BW-1:0] sum_o
);

`ifdef PSUM_SAT_EN
    logic [PSUM_BW:0] ext_sum;

    assign ext_sum = {a_i[PSUM_BW-1], a_i} + {b_i[PSUM_BW-1], b_i};

    // Overflow when the extra sign bit disagrees with the lane sign bit.
    always_comb begin
        sum_o = ext_sum[PSUM_BW-1:0];
        if (ext_sum[PSUM_BW] != ext_sum[PSUM_BW-1]) begin
            sum_o = ext_sum[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
        end
    end
`else
    assign sum_o = a_i + b_i;
`endif

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains psum rows from the array output FIFO into the psum SRAM at consecutive
// addresses, overwriting or read-modify-write accumulating (PSUM_SAT_EN: saturate).
module psum_drain_ctrl
    import psum_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
)
(
    input  logic              clk,
    input  logic              reset,
    psum_drain_ctrl_if.master bus,
    output state_e            state_o
);

    localparam int LAT_CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e              state_q, state_d;
    logic [ADDR_BW:0]    num_q, num_d;
    logic [ADDR_BW:0]    row_q, row_d, row_inc;
    logic [ADDR_BW-1:0]  addr_q, addr_d;
    logic                acc_q, acc_d;
    logic [LAT_CW-1:0]   lat_q, lat_d;
    logic [ROW_BW-1:0]   row_buf_q, row_buf_d;
    logic [ROW_BW-1:0]   sum_row;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            num_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            acc_q     <= 1'b0;
            lat_q     <= '0;
            row_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            lat_q     <= lat_d;
            row_buf_q <= row_buf_d;
        end
    end

    assign row_inc = row_q + (ADDR_BW+1)'(1);

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        row_d     = row_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        lat_d     = lat_q;
        row_buf_d = row_buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    num_d   = bus.num_rows;
                    addr_d  = bus.base_addr;
                    acc_d   = bus.acc;
                    row_d   = '0;
                    state_d = (bus.num_rows == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.ofifo_valid) state_d = S_POP;
            end
            S_POP: begin
                lat_d   = '0;
                state_d = S_LAT;
            end
            S_LAT: begin
                lat_d = lat_q + LAT_CW'(1);
                // The popped row is on ofifo_out during the last latency cycle.
                if (lat_q == LAT_CW'(RD_LAT - 1)) begin
                    row_buf_d = bus.ofifo_out;
                    state_d   = acc_q ? S_RD : S_WR;
                end
            end
            S_RD: state_d = S_WR;
            S_WR: begin
                row_d   = row_inc;
                addr_d  = addr_q + ADDR_BW'(1);
                state_d = (row_inc == num_q) ? S_DONE : S_WAIT;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar i = 0; i < COL; i++) begin : g_lane
        psum_lane_add u_add (
            .a_i   (bus.mem_q[PSUM_BW*i +: PSUM_BW]),
            .b_i   (row_buf_q[PSUM_BW*i +: PSUM_BW]),
            .sum_o (sum_row[PSUM_BW*i +: PSUM_BW])
        );
    end

    // Control outputs decode the state register; mem_q arrives in WR, one cycle after RD.
    assign bus.ofifo_rd = (state_q == S_POP);
    assign bus.mem_cen  = !((state_q == S_RD) || (state_q == S_WR));
    assign bus.mem_wen  = (state_q != S_WR);
    assign bus.mem_addr = addr_q;
    assign bus.mem_d    = (state_q == S_WR) ? (acc_q ? sum_row : row_buf_q) : '0;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Directed bench for psum_drain_ctrl with behavioural output FIFO and psum SRAM models.
// Saturation expectations follow PSUM_SAT_EN.
module tb_psum_drain_ctrl;
    import psum_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_drain_ctrl_if bus();
    state_e state_o;

    psum_drain_ctrl #(.RD_LAT(RD_LAT_DEF)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FIFO / SRAM models ----------------
    logic [ROW_BW-1:0]  mem [0:(1<<ADDR_BW)-1];
    logic [ROW_BW-1:0]  fifo_q[$];
    logic [ROW_BW-1:0]  p1, p2, mem_q_r;
    logic               pre_en = 1'b0, push_en = 1'b0;
    logic [ADDR_BW-1:0] pre_addr = '0;
    logic [ROW_BW-1:0]  pre_data = '0, push_data = '0;

    assign bus.ofifo_out = p2;
    assign bus.mem_q     = mem_q_r;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (push_en) fifo_q.push_back(push_data);
        if (reset) begin
            p1      <= '0;
            p2      <= '0;
            mem_q_r <= '0;
        end else begin
            p2 <= p1;
            if (bus.ofifo_rd && fifo_q.size() > 0) p1 <= fifo_q.pop_front();
            if (!bus.mem_cen && !bus.mem_wen) mem[bus.mem_addr] <= bus.mem_d;
            if (!bus.mem_cen && bus.mem_wen) mem_q_r <= mem[bus.mem_addr];
        end
    end

    // ---------------- monitor ----------------
    logic [ADDR_BW-1:0] wr_addr_q[$];
    logic [ROW_BW-1:0]  wr_data_q[$];
    int                 wr_cyc_q[$];
    int pop_cnt = 0, pop_cyc = 0, mem_rd_cnt = 0, mem_rd_cyc = 0, done_cnt = 0, done_cyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ofifo_rd) begin
                pop_cnt <= pop_cnt + 1;
                pop_cyc <= cyc;
            end
            if (!bus.mem_cen && bus.mem_wen) begin
                mem_rd_cnt <= mem_rd_cnt + 1;
                mem_rd_cyc <= cyc;
            end
            if (!bus.mem_cen && !bus.mem_wen) begin
                wr_addr_q.push_back(bus.mem_addr);
                wr_data_q.push_back(bus.mem_d);
                wr_cyc_q.push_back(cyc);
            end
            if (bus.done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [ROW_BW-1:0]  exp_q[$];
    logic [ADDR_BW-1:0] exp_addr_q[$];

    // ---------------- driver tasks ----------------
    function automatic logic [ROW_BW-1:0] lanes(input logic [PSUM_BW-1:0] v);
        return {COL{v}};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [ADDR_BW-1:0] a, input logic [ROW_BW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic push_row(input logic [ROW_BW-1:0] d);
        push_en = 1'b1; push_data = d;
        tick();
        push_en = 1'b0;
    endtask

    task automatic pulse_start(input int n, input int b, input logic a, output int c0);
        bus.start     = 1'b1;
        bus.num_rows  = (ADDR_BW+1)'(n);
        bus.base_addr = ADDR_BW'(b);
        bus.acc       = a;
        c0 = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (done_cnt != d0) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout got no done required done within 200 cycles", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.num_rows = '0; bus.base_addr = '0; bus.acc = 1'b0;
        bus.ofifo_valid = 1'b0;
        tick(3);
        checks++; if (bus.ofifo_rd !== 1'b0) begin errors++; $display("FAIL rst_ofifo_rd got %b exp 0", bus.ofifo_rd); end
        checks++; if (bus.mem_cen !== 1'b1) begin errors++; $display("FAIL rst_mem_cen got %b exp 1", bus.mem_cen); end
        checks++; if (bus.mem_wen !== 1'b1) begin errors++; $display("FAIL rst_mem_wen got %b exp 1", bus.mem_wen); end
        checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
        checks++; if (bus.mem_d !== '0) begin errors++; $display("FAIL rst_mem_d got %h exp 0", bus.mem_d); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", state_o, S_IDLE); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_overwrite();
        int c0, w0;
        for (int k = 1; k <= 3; k++) push_row(lanes(PSUM_BW'(k)));
        exp_q.delete(); exp_addr_q.delete();
        for (int k = 1; k <= 3; k++) begin
            exp_addr_q.push_back(ADDR_BW'(4 + k));
            exp_q.push_back(lanes(PSUM_BW'(k)));
        end
        bus.ofifo_valid = 1'b1;
        w0 = wr_addr_q.size();
        pulse_start(3, 5, 1'b0, c0);
        wait_done("ovw");
        checks++;
        if (wr_addr_q.size() - w0 != 3) begin
            errors++; $display("FAIL ovw_write_count got %0d exp 3", wr_addr_q.size() - w0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[w0+i] !== exp_addr_q[i]) begin
                    errors++; $display("FAIL ovw_addr%0d got %0d exp %0d", i, wr_addr_q[w0+i], exp_addr_q[i]);
                end
                checks++;
                if (wr_data_q[w0+i] !== exp_q[i]) begin
                    errors++; $display("FAIL ovw_data%0d got %h exp %h", i, wr_data_q[w0+i], exp_q[i]);
                end
            end
            checks++;
            if (wr_cyc_q[w0] != c0 + 5) begin
                errors++; $display("FAIL ovw_first_write_cycle got %0d exp %0d", wr_cyc_q[w0] - c0, 5);
            end
            checks++;
            if (done_cyc != wr_cyc_q[w0+2] + 1) begin
                errors++; $display("FAIL ovw_done_after_wr got %0d exp %0d", done_cyc, wr_cyc_q[w0+2] + 1);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ovw_busy_after_done got %b exp 0", bus.busy); end
        bus.ofifo_valid = 1'b0;
        tick();
    endtask

    task automatic test_accumulate();
        int c0, w0, r0;
        preload(6'd10, lanes(16'd100));
        push_row(lanes(16'd23));
        bus.ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); r0 = mem_rd_cnt;
        pulse_start(1, 10, 1'b1, c0);
        wait_done("acc");
        bus.ofifo_valid = 1'b0;
        checks++;
        if (mem_rd_cnt - r0 != 1) begin errors++; $display("FAIL acc_read_count got %0d exp 1", mem_rd_cnt - r0); end
        checks++;
        if (wr_addr_q.size() - w0 != 1) begin
            errors++; $display("FAIL acc_write_count got %0d exp 1", wr_addr_q.size() - w0);
        end else begin
            checks++;
            if (wr_addr_q[w0] !== 6'd10) begin errors++; $display("FAIL acc_addr got %0d exp 10", wr_addr_q[w0]); end
            checks++;
            if (wr_data_q[w0] !== lanes(16'd123)) begin errors++; $display("FAIL acc_data got %h exp %h", wr_data_q[w0], lanes(16'd123)); end
            checks++;
            if (mem_rd_cyc != wr_cyc_q[w0] - 1) begin errors++; $display("FAIL acc_rd_before_wr got %0d exp %0d", mem_rd_cyc, wr_cyc_q[w0] - 1); end
            checks++;
            if (wr_cyc_q[w0] != c0 + 6) begin errors++; $display("FAIL acc_write_cycle got %0d exp 6", wr_cyc_q[w0] - c0); end
        end
        tick();
    endtask

    task automatic test_saturation();
        int c0, w0;
        logic [ROW_BW-1:0] m, f, e;
        m = '0; f = '0; e = '0;
        m[15:0] = 16'h7FF0;  f[15:0] = 16'h0020;
        m[31:16] = 16'h8010; f[31:16] = 16'hFFE0;
        m[47:32] = 16'h0005; f[47:32] = 16'h0003; e[47:32] = 16'h0008;
        m[63:48] = 16'hFFFF; f[63:48] = 16'hFFFF; e[63:48] = 16'hFFFE;
`ifdef PSUM_SAT_EN
        e[15:0] = 16'h7FFF; e[31:16] = 16'h8000;
`else
        e[15:0] = 16'h8010; e[31:16] = 16'h7FF0;
`endif
        preload(6'd20, m);
        push_row(f);
        bus.ofifo_valid = 1'b1;
        w0 = wr_addr_q.size();
        pulse_start(1, 20, 1'b1, c0);
        wait_done("sat");
        bus.ofifo_valid = 1'b0;
        checks++;
        if (wr_addr_q.size() - w0 != 1) begin
            errors++; $display("FAIL sat_write_count got %0d exp 1", wr_addr_q.size() - w0);
        end else begin
            checks++;
            if (wr_data_q[w0] !== e) begin errors++; $display("FAIL sat_data got %h exp %h", wr_data_q[w0], e); end
        end
        tick();
    endtask

    task automatic test_stall();
        int c0, cv, w0, p0, r0;
        bus.ofifo_valid = 1'b0;
        push_row(lanes(16'h0ABC));
        w0 = wr_addr_q.size(); p0 = pop_cnt; r0 = mem_rd_cnt;
        pulse_start(1, 30, 1'b0, c0);
        tick(20);
        checks++; if (pop_cnt != p0) begin errors++; $display("FAIL stall_no_pop got %0d exp 0", pop_cnt - p0); end
        checks++;
        if ((wr_addr_q.size() != w0) || (mem_rd_cnt != r0)) begin
            errors++; $display("FAIL stall_no_sram got %0d exp 0", wr_addr_q.size() - w0 + mem_rd_cnt - r0);
        end
        checks++; if (state_o !== S_WAIT) begin errors++; $display("FAIL stall_state got %0d exp %0d", state_o, S_WAIT); end
        bus.ofifo_valid = 1'b1;
        cv = cyc;
        wait_done("stall");
        bus.ofifo_valid = 1'b0;
        checks++; if (pop_cyc != cv + 1) begin errors++; $display("FAIL stall_pop_cycle got %0d exp %0d", pop_cyc - cv, 1); end
        checks++;
        if ((wr_addr_q.size() - w0 != 1) || (wr_data_q[wr_data_q.size()-1] !== lanes(16'h0ABC))) begin
            errors++; $display("FAIL stall_write got %0d writes exp 1 with %h", wr_addr_q.size() - w0, lanes(16'h0ABC));
        end
        tick();
    endtask

    task automatic test_wrap();
        int c0, w0, p0, r0;
        push_row(lanes(16'h0011));
        push_row(lanes(16'h0022));
        bus.ofifo_valid = 1'b1;
        w0 = wr_addr_q.size();
        pulse_start(2, 63, 1'b0, c0);
        wait_done("wrap");
        bus.ofifo_valid = 1'b0;
        checks++;
        if (wr_addr_q.size() - w0 != 2) begin
            errors++; $display("FAIL wrap_write_count got %0d exp 2", wr_addr_q.size() - w0);
        end else begin
            checks++;
            if (wr_addr_q[w0] !== 6'd63 || wr_addr_q[w0+1] !== 6'd0) begin
                errors++; $display("FAIL wrap_addrs got %0d,%0d exp 63,0", wr_addr_q[w0], wr_addr_q[w0+1]);
            end
            checks++;
            if (wr_data_q[w0+1] !== lanes(16'h0022)) begin errors++; $display("FAIL wrap_data got %h exp %h", wr_data_q[w0+1], lanes(16'h0022)); end
        end
        tick();
        w0 = wr_addr_q.size(); p0 = pop_cnt; r0 = mem_rd_cnt;
        pulse_start(0, 7, 1'b1, c0);
        wait_done("zero");
        checks++; if (done_cyc != c0 + 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc - c0); end
        checks++;
        if ((pop_cnt != p0) || (wr_addr_q.size() != w0) || (mem_rd_cnt != r0)) begin
            errors++; $display("FAIL zero_no_access got %0d exp 0", pop_cnt - p0 + wr_addr_q.size() - w0 + mem_rd_cnt - r0);
        end
        tick();
    endtask

    task automatic test_reset_in_lat();
        int c0, w0, r0;
        bit hit;
        preload(6'd40, lanes(16'd1));
        push_row(lanes(16'd2));
        bus.ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); r0 = mem_rd_cnt;
        pulse_start(1, 40, 1'b1, c0);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (state_o == S_LAT) hit = 1;
            else tick();
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rlat_reach_lat got state %0d exp %0d", state_o, S_LAT); end
        reset = 1'b1;
        tick();
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL rlat_state got %0d exp %0d", state_o, S_IDLE); end
        checks++; if (bus.mem_cen !== 1'b1) begin errors++; $display("FAIL rlat_mem_cen got %b exp 1", bus.mem_cen); end
        reset = 1'b0;
        bus.ofifo_valid = 1'b0;
        tick(10);
        checks++;
        if ((wr_addr_q.size() != w0) || (mem_rd_cnt != r0)) begin
            errors++; $display("FAIL rlat_no_write got %0d exp 0", wr_addr_q.size() - w0 + mem_rd_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int c0, w0, d0;
        push_row(lanes(16'h0055));
        bus.ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); d0 = done_cnt;
        pulse_start(1, 50, 1'b0, c0);
        bus.start = 1'b1; bus.num_rows = 7'd5; bus.base_addr = 6'd0; bus.acc = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("b2b");
        bus.ofifo_valid = 1'b0;
        tick(8);
        checks++;
        if ((wr_addr_q.size() - w0 != 1) || (wr_addr_q[wr_addr_q.size()-1] !== 6'd50)) begin
            errors++; $display("FAIL b2b_single_write got %0d writes exp 1 at 50", wr_addr_q.size() - w0);
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_done_count got %0d exp 1", done_cnt - d0); end
        checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL b2b_state got %0d exp %0d", state_o, S_IDLE); end
    endtask

    initial begin
        test_reset();
        test_overwrite();
        test_accumulate();
        test_saturation();
        test_stall();
        test_wrap();
        test_reset_in_lat();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
